// File: rtl/load_store_unit.sv
// Load/store unit: takes one data-memory access from execute, runs it over a
// req/ack bus, and returns extended load data with a one-cycle done pulse.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for exactly one of mem_read/mem_write
// REQ    | bus_req held with stable attributes until bus_ack or timeout
// DONE   | lsu_done pulse, lsu_err qualifies it; pipeline released
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        lsu_busy,
   output logic        lsu_done,
   output logic        lsu_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [31:0]   sd_q, sd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   load_data_q, load_data_d;
   logic          err_q, err_d;

   logic          in_req;
   logic          timeout_hit;
   logic          bad_funct3;
   logic          misaligned;
   logic [3:0]    be_raw;
   logic [31:0]   wdata_raw;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   rd_ext;

   assign in_req      = (state_q == S_REQ);
   // The ack-less REQ cycle that would be number TIMEOUT ends the access.
   assign timeout_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 32'd1);

   // Legality and alignment of the incoming request (evaluated in IDLE).
   always_comb begin
      bad_funct3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (mem_write && funct3[2]);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   end

   // Byte enables, replicated write data and extended read data from the latched access.
   always_comb begin
      be_raw    = 4'b1111;
      wdata_raw = sd_q;
      case (funct3_q[1:0])
         2'b00: begin
            be_raw    = 4'b0001 << addr_q[1:0];
            wdata_raw = {4{sd_q[7:0]}};
         end
         2'b01: begin
            be_raw    = 4'b0011 << addr_q[1:0];
            wdata_raw = {2{sd_q[15:0]}};
         end
         default: ;
      endcase
      case (addr_q[1:0])
         2'b00:   rd_byte = bus_rdata[7:0];
         2'b01:   rd_byte = bus_rdata[15:8];
         2'b10:   rd_byte = bus_rdata[23:16];
         default: rd_byte = bus_rdata[31:24];
      endcase
      rd_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (funct3_q)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  rd_ext = {24'd0, rd_byte};
         3'b101:  rd_ext = {16'd0, rd_half};
         default: rd_ext = bus_rdata;
      endcase
   end

   // Next-state logic: accept, bus handshake with timeout, completion.
   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      funct3_d    = funct3_q;
      sd_d        = sd_q;
      cnt_d       = cnt_q;
      load_data_d = load_data_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            err_d = 1'b0;
            if (mem_read || mem_write) begin
               we_d        = mem_write;
               addr_d      = addr;
               funct3_d    = funct3;
               sd_d        = store_data;
               load_data_d = '0;
               if ((mem_read && mem_write) || bad_funct3 || misaligned) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (bus_ack) begin
               if (!we_q) load_data_d = rd_ext;
               state_d = S_DONE;
            end else if (timeout_hit) begin
               err_d       = 1'b1;
               load_data_d = '0;
               state_d     = S_DONE;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         funct3_q    <= '0;
         sd_q        <= '0;
         cnt_q       <= '0;
         load_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         funct3_q    <= funct3_d;
         sd_q        <= sd_d;
         cnt_q       <= cnt_d;
         load_data_q <= load_data_d;
         err_q       <= err_d;
      end
   end

   assign load_data = load_data_q;
   assign lsu_busy  = in_req;
   assign lsu_done  = (state_q == S_DONE);
   assign lsu_err   = (state_q == S_DONE) && err_q;
   assign bus_req   = in_req;
   assign bus_we    = in_req && we_q;
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_be    = in_req ? be_raw : 4'b0000;
   assign bus_wdata = wdata_raw;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores of every size, error paths,
// timeout boundary and reset during a bus access.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic [31:0] load_data;
   logic        lsu_busy, lsu_done, lsu_err;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .addr(addr), .store_data(store_data), .load_data(load_data),
      .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a request for one cycle (the accept cycle), then scramble the inputs
   // so the DUT must rely on its latched copy. Returns at the first post-accept cycle.
   task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
      step();
      mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b111;
      addr = 32'hFFFF_FFFF; store_data = 32'h5555_5555;
   endtask

   // Ack in the current (first REQ) cycle, then land in the DONE cycle.
   task automatic ack_now(input logic [31:0] rdata);
      bus_ack = 1'b1; bus_rdata = rdata;
      step();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
      addr = 32'h0; store_data = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
      step(); step();
      @(negedge clk);
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_busy", 32'(lsu_busy), 32'd0);
      chk("rst_done", 32'(lsu_done), 32'd0);
      chk("rst_err", 32'(lsu_err), 32'd0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_be", 32'(bus_be), 32'h0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'h0);
      step();
      rst = 1'b0;

      // LW 0x100: accept cycle, REQ with ack, DONE.
      mem_read = 1'b1; funct3 = 3'b010; addr = 32'h100;
      @(negedge clk);
      chk("lw_busy_accept", 32'(lsu_busy), 32'd0);
      #4;
      issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
      @(negedge clk);
      chk("lw_bus_req", 32'(bus_req), 32'd1);
      chk("lw_busy", 32'(lsu_busy), 32'd1);
      chk("lw_be", 32'(bus_be), 32'hF);
      chk("lw_bus_addr", bus_addr, 32'h100);
      chk("lw_we", 32'(bus_we), 32'd0);
      chk("lw_done_early", 32'(lsu_done), 32'd0);
      #4;
      ack_now(32'hDEAD_BEEF);
      chk("lw_done", 32'(lsu_done), 32'd1);
      chk("lw_err", 32'(lsu_err), 32'd0);
      chk("lw_data", load_data, 32'hDEAD_BEEF);
      chk("lw_req_dropped", 32'(bus_req), 32'd0);
      chk("lw_busy_done", 32'(lsu_busy), 32'd0);
      #4;
      step();
      @(negedge clk);
      chk("lw_done_pulse", 32'(lsu_done), 32'd0);
      #4;
      step();

      // LB 0x103 -> sign-extended top lane.
      issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
      @(negedge clk);
      chk("lb_be", 32'(bus_be), 32'h8);
      chk("lb_bus_addr", bus_addr, 32'h100);
      #4;
      ack_now(32'h80FF_0000);
      chk("lb_data", load_data, 32'hFFFF_FF80);
      #4; step(); step();

      // LBU 0x103 -> zero-extended.
      issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
      #4;
      ack_now(32'h80FF_0000);
      chk("lbu_data", load_data, 32'h0000_0080);
      chk("lbu_err", 32'(lsu_err), 32'd0);
      #4; step(); step();

      // LH 0x102 -> upper half sign-extended.
      issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0);
      @(negedge clk);
      chk("lh_be", 32'(bus_be), 32'hC);
      #4;
      ack_now(32'h80FF_0000);
      chk("lh_data", load_data, 32'hFFFF_80FF);
      #4; step(); step();

      // LHU 0x100 -> lower half zero-extended.
      issue(1'b1, 1'b0, 3'b101, 32'h100, 32'h0);
      #4;
      ack_now(32'h1234_F00D);
      chk("lhu_data", load_data, 32'h0000_F00D);
      #4; step(); step();

      // SH 0x202.
      issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD);
      @(negedge clk);
      chk("sh_be", 32'(bus_be), 32'hC);
      chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
      chk("sh_bus_addr", bus_addr, 32'h200);
      chk("sh_we", 32'(bus_we), 32'd1);
      #4;
      ack_now(32'h0);
      chk("sh_done", 32'(lsu_done), 32'd1);
      chk("sh_err", 32'(lsu_err), 32'd0);
      #4; step(); step();

      // SB 0x101.
      issue(1'b0, 1'b1, 3'b000, 32'h101, 32'h0000_00A5);
      @(negedge clk);
      chk("sb_be", 32'(bus_be), 32'h2);
      chk("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
      #4;
      ack_now(32'h0);
      chk("sb_done", 32'(lsu_done), 32'd1);
      #4; step(); step();

      // Misaligned LW: done+err the cycle after accept, no bus access.
      issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
      @(negedge clk);
      chk("mis_done", 32'(lsu_done), 32'd1);
      chk("mis_err", 32'(lsu_err), 32'd1);
      chk("mis_req", 32'(bus_req), 32'd0);
      chk("mis_busy", 32'(lsu_busy), 32'd0);
      #4; step();
      @(negedge clk);
      chk("mis_done_pulse", 32'(lsu_done), 32'd0);
      #4;

      // Both read and write high.
      issue(1'b1, 1'b1, 3'b010, 32'h100, 32'h0);
      @(negedge clk);
      chk("both_done", 32'(lsu_done), 32'd1);
      chk("both_err", 32'(lsu_err), 32'd1);
      chk("both_req", 32'(bus_req), 32'd0);
      #4; step();

      // Store with funct3[2]=1 is illegal.
      issue(1'b0, 1'b1, 3'b100, 32'h100, 32'h0);
      @(negedge clk);
      chk("sbu_err", 32'(lsu_err), 32'd1);
      chk("sbu_req", 32'(bus_req), 32'd0);
      #4; step();

      // Reserved load funct3.
      issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
      @(negedge clk);
      chk("f3_err", 32'(lsu_err), 32'd1);
      #4; step();

      // Timeout: 16 REQ cycles without ack.
      issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         chk($sformatf("to_req_%0d", i), 32'(bus_req), 32'd1);
         #4;
         step();
      end
      @(negedge clk);
      chk("to_done", 32'(lsu_done), 32'd1);
      chk("to_err", 32'(lsu_err), 32'd1);
      chk("to_data", load_data, 32'h0);
      chk("to_req", 32'(bus_req), 32'd0);
      #4; step();

      // Ack on the 16th REQ cycle wins over the timeout.
      issue(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
      for (int i = 1; i <= 15; i++) step();
      @(negedge clk);
      chk("late_ack_req", 32'(bus_req), 32'd1);
      #4;
      ack_now(32'hCAFE_F00D);
      chk("late_ack_done", 32'(lsu_done), 32'd1);
      chk("late_ack_err", 32'(lsu_err), 32'd0);
      chk("late_ack_data", load_data, 32'hCAFE_F00D);
      #4; step(); step();

      // Reset in the middle of REQ, then a stray ack.
      issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
      @(negedge clk);
      chk("rr_req_before", 32'(bus_req), 32'd1);
      #4;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rr_req", 32'(bus_req), 32'd0);
      chk("rr_busy", 32'(lsu_busy), 32'd0);
      chk("rr_done", 32'(lsu_done), 32'd0);
      #4;
      bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
      step();
      bus_ack = 1'b0;
      @(negedge clk);
      chk("stray_done", 32'(lsu_done), 32'd0);
      chk("stray_busy", 32'(lsu_busy), 32'd0);
      #4; step();
      @(negedge clk);
      chk("stray_done2", 32'(lsu_done), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
